// File: rtl/cordic_feeder_pkg.sv
// Shared types and constants for the CORDIC feeder: FSM state encoding, register
// addresses of the accelerator slave port and the word written to clear it.
package cordic_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      READ   = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam logic        ADDR_DATA  = 1'b0;
   localparam logic        ADDR_CTRL  = 1'b1;
   localparam logic [31:0] CLEAR_WORD = 32'h0;

endpackage

// File: rtl/cordic_feeder_if.sv
// Signal bundle between the CORDIC feeder and its environment: sample stream in,
// start/length control, result strobe, and the Avalon-MM initiator port.
interface cordic_feeder_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   // Sample stream: a word transfers on a cycle where in_valid && in_ready; the
   // producer keeps in_data stable while in_valid is high. On Avalon, a request
   // (avm_write/avm_read) completes on a cycle with !avm_waitrequest and all
   // avm_* outputs hold stable while it is stalled.
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              err;
   logic              avm_address;
   logic              avm_write;
   logic              avm_read;
   logic [DATA_W-1:0] avm_writedata;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_waitrequest;

   modport master (
      input  in_valid, in_data, start, len, avm_readdata, avm_waitrequest,
      output in_ready, busy, res_valid, res_data, err,
             avm_address, avm_write, avm_read, avm_writedata
   );

   modport slave (
      output in_valid, in_data, start, len, avm_readdata, avm_waitrequest,
      input  in_ready, busy, res_valid, res_data, err,
             avm_address, avm_write, avm_read, avm_writedata
   );

endinterface

// File: rtl/feeder_fifo.sv
// Synchronous sample FIFO with registered full/empty flags; the head word is read
// straight from storage so it is valid in the same cycle the FIFO is non-empty.
module feeder_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic [AW:0]       count_d;
   logic              full_q;
   logic              empty_q;
   logic              do_push;
   logic              do_pop;

   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == (AW+1)'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/cordic_feeder.sv
// Avalon-MM initiator that clears the CORDIC accelerator, streams FIFO samples into it
// and reads back the result. Define CORDIC_FEEDER_TIMEOUT_EN to add the waitrequest watchdog.
module cordic_feeder
   import cordic_feeder_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   cordic_feeder_if.master bus,
   output state_e          state_o
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              ctrl_wr_q, ctrl_wr_d;
   logic              rd_q, rd_d;
   logic              addr_q, addr_d;
   logic              stream_q, stream_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              busy_q, busy_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              pop;
   logic              wr_accept;

   feeder_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (bus.in_valid),
      .push_data_i (bus.in_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Data writes are offered only while a sample sits at the FIFO head.
   assign bus.avm_write     = ctrl_wr_q || (stream_q && !fifo_empty);
   assign bus.avm_read      = rd_q;
   assign bus.avm_address   = addr_q;
   assign bus.avm_writedata = stream_q ? fifo_head : DATA_W'(CLEAR_WORD);
   assign bus.in_ready      = !fifo_full;
   assign bus.busy          = busy_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_data      = res_data_q;
   assign state_o           = state_q;

   assign wr_accept = bus.avm_write && !bus.avm_waitrequest;
   assign pop       = stream_q && wr_accept;

`ifdef CORDIC_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] stall_cnt_q, stall_cnt_d;
   logic          err_q, err_d;
   logic          stall;
   logic          abort;

   assign stall = (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
   assign abort = stall && (stall_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      stall_cnt_d = '0;
      if (stall && !abort) stall_cnt_d = stall_cnt_q + 1'b1;
      err_d = abort;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      res_data_d = res_data_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               rem_d   = bus.len;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (!bus.avm_waitrequest) state_d = (rem_q == '0) ? READ : STREAM;
         end
         STREAM: begin
            if (wr_accept) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == LEN_W'(1)) state_d = READ;
            end
         end
         READ: begin
            if (!bus.avm_waitrequest) begin
               res_data_d = bus.avm_readdata;
               state_d    = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef CORDIC_FEEDER_TIMEOUT_EN
      if (abort) state_d = IDLE;
`endif
      // Avalon strobes are registered from the next state so they line up with it.
      ctrl_wr_d   = (state_d == CLEAR);
      rd_d        = (state_d == READ);
      stream_d    = (state_d == STREAM);
      addr_d      = (state_d == CLEAR) ? ADDR_CTRL : ADDR_DATA;
      res_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         ctrl_wr_q   <= 1'b0;
         rd_q        <= 1'b0;
         addr_q      <= 1'b0;
         stream_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         ctrl_wr_q   <= ctrl_wr_d;
         rd_q        <= rd_d;
         addr_q      <= addr_d;
         stream_q    <= stream_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: doc/cordic_feeder.md
# cordic_feeder

Hardware Avalon-MM initiator that drives the CORDIC accelerator's two-register slave port in place of a software or bench master. Upstream logic streams float32 samples into an internal FIFO and pulses `start` with a sample count. The block then issues a clear write to the control register, writes each sample to the data register, reads back the accumulated result, and presents it on a one-cycle result strobe. It sits between a sample producer and the accelerator's `top` slave interface.

## Interface
- `DATA_W`, 32: sample, result and Avalon data width.
- `DEPTH`, 16: sample FIFO entries; power of two, at least 2.
- `LEN_W`, 8: width of the sample-count field.
- `TIMEOUT`, 255: waitrequest watchdog limit in cycles. Used only under `CORDIC_FEEDER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample present.
- `in_ready` out 1: FIFO can accept (`!full`).
- `in_data` in DATA_W: float32 sample.
- `start` in 1: begin transaction. Sampled only in IDLE.
- `len` in LEN_W: number of samples to send, captured with `start`.
- `busy` out 1: high in any state except IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out DATA_W: result word, held until the next strobe.
- `err` out 1: one-cycle timeout strobe. Tied to 0 when the watchdog is compiled out.
- `avm_address` out 1: 1 = control register, 0 = data register.
- `avm_write` out 1: Avalon write request.
- `avm_read` out 1: Avalon read request.
- `avm_writedata` out DATA_W: Avalon write data.
- `avm_readdata` in DATA_W: Avalon read data.
- `avm_waitrequest` in 1: slave stall.

## Operation
- The FIFO accepts pushes in every state, including IDLE, so it can be prefilled.
  - Push when `in_valid && in_ready`.
  - Pop when a data write is accepted.
  - Push is blocked when full, even on a pop cycle.
  - No pop occurs while empty.
- State IDLE: on `start`, latch `len` into `remaining` and go to CLEAR. `start` is ignored in any other state.
- State CLEAR: drive `avm_write=1`, `avm_address=1`, `avm_writedata=0`. Hold until `!avm_waitrequest`.
  - If `remaining==0`, go to READ.
  - Otherwise go to STREAM.
- State STREAM: `avm_address=0`; `avm_writedata` = FIFO head; `avm_write` = FIFO non-empty.
  - A write is accepted when `avm_write && !avm_waitrequest`. On acceptance: pop, decrement `remaining`.
  - After the acceptance that brings `remaining` to 0, go to READ.
  - While the FIFO is empty, write deasserts and the block stalls in STREAM without limit.
- State READ: drive `avm_read=1`, `avm_address=0`. On `!avm_waitrequest`, capture `avm_readdata` into `res_data` and go to DONE.
- State DONE: `res_valid=1` for one cycle, then IDLE.
- Samples beyond `len` stay in the FIFO for the next transaction.
- Reset mid-operation returns to IDLE and empties the FIFO. Any in-flight Avalon request is dropped.
- Reset values of all outputs:
  - `avm_write`, `avm_read`, `avm_address`, `avm_writedata` = 0.
  - `res_valid`, `res_data`, `busy`, `err` = 0.
  - `in_ready` = 1 from the first cycle after reset.

## Timing
- All Avalon outputs are registered, except that `avm_writedata` in STREAM comes straight from the FIFO head register.
- Avalon signals are held stable while `avm_waitrequest` is high.
- Read latency is 0: readdata is valid in the cycle the read is accepted.
- Zero waitrequest, FIFO prefilled with N samples, `start` at cycle 0:
  - CLEAR write at cycle 1.
  - Data writes at cycles 2 to N+1.
  - Read at cycle N+2.
  - `res_valid` at cycle N+3.
- `len=0` gives `res_valid` at cycle 3.
- Each waitrequest cycle or empty-FIFO cycle adds exactly one cycle.

## Configuration
- `CORDIC_FEEDER_TIMEOUT_EN` defined:
  - A counter runs while a request is stalled by `avm_waitrequest`.
  - At TIMEOUT consecutive stall cycles: drop the request, pulse `err` for one cycle, go to IDLE.
  - No `res_valid` is produced for an aborted transaction, and FIFO contents are kept.
- Not defined: no counter, `err` tied to 0, the block stalls indefinitely.

## Structure
- Package `cordic_feeder_pkg` holds:
  - the state enum (IDLE, CLEAR, STREAM, READ, DONE);
  - `ADDR_DATA = 1'b0` and `ADDR_CTRL = 1'b1`;
  - `CLEAR_WORD = 32'h0`.
- One sub-module, `feeder_fifo`: synchronous FIFO with registered head, `full` and `empty` flags, and a single push/pop port pair.

## Test plan
- Prefill 6 samples (`43000000`, `42080000`, `42be0000`, `42f40000`, `42a40000`, `42800000`), then `start` with `len=6`, no waitrequest:
  - one CLEAR write of 0 to address 1, then the 6 writes to address 0 in order;
  - read at cycle 8; slave returns `437f0000`; `res_valid` with `res_data=437f0000` at cycle 9.
- `len=0`: CLEAR write, then read; `res_valid` at cycle 3; FIFO untouched.
- Waitrequest high for 3 cycles on the second data write:
  - address and data held stable for all stalled cycles;
  - `res_valid` arrives 3 cycles later than the no-stall case.
- Stream starved: `start` with `len=4` and empty FIFO, samples fed one every 5 cycles:
  - `avm_write` deasserts between samples;
  - exactly 4 writes, then the read.
- FIFO full (DEPTH pushes) → `in_ready=0`. Assert `reset` mid-STREAM:
  - next cycle all outputs are 0 and `in_ready=1`;
  - a following `start` performs a fresh CLEAR.
- With `CORDIC_FEEDER_TIMEOUT_EN`, `TIMEOUT=8`, and `avm_waitrequest` held high in READ:
  - `err` pulses once after 8 stall cycles;
  - `busy` drops and `res_valid` never asserts.
